// File: rtl/mem_bus_bridge_pkg.sv
// Shared definitions for the single-cycle datapath to valid/ready memory bus bridge.
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Returned as load data when a read response never arrives.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Datapath-side memory access signals plus the request/response bus of the bridge.
interface mem_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] ALUOut;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Stall;
  logic                  BusReqValid;
  logic                  BusReqReady;
  logic                  BusReqWe;
  logic [ADDR_WIDTH-1:0] BusReqAddr;
  logic [DATA_WIDTH-1:0] BusReqWdata;
  logic                  BusRspValid;
  logic [DATA_WIDTH-1:0] BusRspRdata;
  logic                  BusError;

  // The bridge is the bus master; the datapath and memory together form the other side.
  modport master (
    input  MemRead, MemWrite, ALUOut, WriteData, BusReqReady, BusRspValid, BusRspRdata,
    output ReadData, Stall, BusReqValid, BusReqWe, BusReqAddr, BusReqWdata, BusError
  );

  modport slave (
    output MemRead, MemWrite, ALUOut, WriteData, BusReqReady, BusRspValid, BusRspRdata,
    input  ReadData, Stall, BusReqValid, BusReqWe, BusReqAddr, BusReqWdata, BusError
  );
endinterface

// File: rtl/bus_timeout_counter.sv
// Response-wait watchdog for mem_bus_bridge; only compiled when MEM_BUS_TIMEOUT_EN is defined.
`ifdef MEM_BUS_TIMEOUT_EN
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expires on the last permitted wait cycle so the FSM leaves exactly TIMEOUT_CYCLES after entry.
  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule
`endif

// File: rtl/mem_bus_bridge.sv
// Turns the datapath's combinational load/store into a valid/ready bus access and stalls until done.
// Optional response timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_bus_bridge_if.master  bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  access;
  logic                  accept;
  logic                  timeout;
  logic                  unused_addr_bits;

  assign access           = bus.MemRead | bus.MemWrite;
  assign accept           = (state_q == REQ) & bus.BusReqReady;
  assign unused_addr_bits = ^bus.ALUOut[1:0];

`ifdef MEM_BUS_TIMEOUT_EN
  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (accept & ~we_q),
    .enable_i (state_q == RSP),
    .expired_o(timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A store wins when both strobes are raised.
        if (access) begin
          state_d = REQ;
          addr_d  = {bus.ALUOut[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = bus.WriteData;
          we_d    = bus.MemWrite;
        end
      end
      REQ: begin
        if (bus.BusReqReady) begin
          state_d = we_q ? DONE : RSP;
        end
      end
      RSP: begin
        if (bus.BusRspValid) begin
          rdata_d = bus.BusRspRdata;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = DATA_WIDTH'(TIMEOUT_RDATA);
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stall rises combinationally so the datapath freezes in the cycle it presents the access.
  assign bus.Stall       = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == RSP);
  assign bus.BusReqValid = (state_q == REQ);
  assign bus.BusReqWe    = we_q;
  assign bus.BusReqAddr  = addr_q;
  assign bus.BusReqWdata = wdata_q;
  assign bus.ReadData    = rdata_q;
  assign bus.BusError    = err_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: cycle table plus reset and response-wait sequences.
module tb_mem_bus_bridge;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rspValid;
    logic [31:0] rspData;
    logic        expStall;
    logic        expValid;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_bus_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_bus_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ready, input logic rspValid,
                              input logic [31:0] rspData, input logic expStall, input logic expValid,
                              input logic expWe, input logic [31:0] expAddr,
                              input logic [31:0] expWdata, input logic [31:0] expRdata,
                              input logic expErr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ready = ready;
    v.rspValid = rspValid; v.rspData = rspData;
    v.expStall = expStall; v.expValid = expValid; v.expWe = expWe; v.expAddr = expAddr;
    v.expWdata = expWdata; v.expRdata = expRdata; v.expErr = expErr;
    return v;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveInputs(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic ready, input logic rspValid,
                             input logic [31:0] rspData);
    bus.MemRead     = rd;
    bus.MemWrite    = wr;
    bus.ALUOut      = addr;
    bus.WriteData   = wdata;
    bus.BusReqReady = ready;
    bus.BusRspValid = rspValid;
    bus.BusRspRdata = rspData;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v.rd, v.wr, v.addr, v.wdata, v.ready, v.rspValid, v.rspData);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic stall, input logic valid, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic err);
    checkOutput({tag, ".Stall"},       32'(bus.Stall),       32'(stall));
    checkOutput({tag, ".BusReqValid"}, 32'(bus.BusReqValid), 32'(valid));
    checkOutput({tag, ".BusReqWe"},    32'(bus.BusReqWe),    32'(we));
    checkOutput({tag, ".BusReqAddr"},  bus.BusReqAddr,       addr);
    checkOutput({tag, ".BusReqWdata"}, bus.BusReqWdata,      wdata);
    checkOutput({tag, ".ReadData"},    bus.ReadData,         rdata);
    checkOutput({tag, ".BusError"},    32'(bus.BusError),    32'(err));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Cycle-by-cycle table: load, stalled store, dual strobe, back-to-back loads, stale response.
    vecs.push_back(mk(1,0,32'h13,0,1,0,0,                1,0,0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,32'h13,0,1,0,0,                1,1,0,32'h10,0,0,0));
    vecs.push_back(mk(1,0,32'h13,0,1,1,32'h1234_5678,    1,0,0,32'h10,0,0,0));
    vecs.push_back(mk(1,0,32'h13,0,1,0,0,                0,0,0,32'h10,0,32'h1234_5678,0));
    vecs.push_back(mk(0,1,32'h104,32'hCAFE_F00D,0,0,0,   1,0,0,32'h10,0,32'h1234_5678,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFF0,0,0,0,0,         1,1,1,32'h104,32'hCAFE_F00D,32'h1234_5678,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFF0,0,0,0,0,         1,1,1,32'h104,32'hCAFE_F00D,32'h1234_5678,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFF0,0,0,0,0,         1,1,1,32'h104,32'hCAFE_F00D,32'h1234_5678,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFF0,0,1,0,0,         1,1,1,32'h104,32'hCAFE_F00D,32'h1234_5678,0));
    vecs.push_back(mk(0,1,32'h104,32'hCAFE_F00D,1,0,0,   0,0,1,32'h104,32'hCAFE_F00D,32'h1234_5678,0));
    vecs.push_back(mk(1,1,32'h20,32'h1111_2222,1,0,0,    1,0,1,32'h104,32'hCAFE_F00D,32'h1234_5678,0));
    vecs.push_back(mk(1,1,32'h20,32'h1111_2222,1,0,0,    1,1,1,32'h20,32'h1111_2222,32'h1234_5678,0));
    vecs.push_back(mk(1,1,32'h20,32'h1111_2222,1,0,0,    0,0,1,32'h20,32'h1111_2222,32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h40,0,1,0,0,                1,0,1,32'h20,32'h1111_2222,32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h40,0,1,0,0,                1,1,0,32'h40,0,32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h40,0,1,1,32'hAAAA_0001,    1,0,0,32'h40,0,32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h40,0,1,0,0,                0,0,0,32'h40,0,32'hAAAA_0001,0));
    vecs.push_back(mk(1,0,32'h44,0,1,0,0,                1,0,0,32'h40,0,32'hAAAA_0001,0));
    vecs.push_back(mk(1,0,32'h44,0,1,0,0,                1,1,0,32'h44,0,32'hAAAA_0001,0));
    vecs.push_back(mk(1,0,32'h44,0,1,0,0,                1,0,0,32'h44,0,32'hAAAA_0001,0));
    vecs.push_back(mk(1,0,32'h44,0,1,1,32'h5555_0002,    1,0,0,32'h44,0,32'hAAAA_0001,0));
    vecs.push_back(mk(0,0,32'h44,0,1,0,0,                0,0,0,32'h44,0,32'h5555_0002,0));
    vecs.push_back(mk(0,0,32'h0,0,1,1,32'h9999_9999,     0,0,0,32'h44,0,32'h5555_0002,0));
    vecs.push_back(mk(0,0,32'h0,0,1,0,0,                 0,0,0,32'h44,0,32'h5555_0002,0));

    rst = 1'b1;
    driveInputs(0, 0, 32'h0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    repeat (2) stepCycle();
    checkAll("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    rst = 1'b0;
    driveInputs(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expValid, vecs[i].expWe,
               vecs[i].expAddr, vecs[i].expWdata, vecs[i].expRdata, vecs[i].expErr);
      stepCycle();
    end

    // Reset while waiting for a read response, then a late response must be ignored.
    driveInputs(1, 0, 32'h80, 32'h0, 1, 0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("rstmid.inRsp.Stall", 32'(bus.Stall), 32'd1);
    checkOutput("rstmid.inRsp.BusReqValid", 32'(bus.BusReqValid), 32'd0);
    rst = 1'b1;
    driveInputs(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    stepCycle();
    rst = 1'b0;
    checkAll("rstmid.after", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    driveInputs(0, 0, 32'h0, 32'h0, 1, 1, 32'h7777_7777);
    #1;
    checkOutput("rstmid.stale.Stall", 32'(bus.Stall), 32'd0);
    stepCycle();
    driveInputs(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    stepCycle();
    checkAll("rstmid.ignored", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

    // Read whose response is late or missing.
    driveInputs(1, 0, 32'h100, 32'h0, 1, 0, 32'h0);
    stepCycle();
    stepCycle();
`ifdef MEM_BUS_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("timeout.wait%0d.Stall", c), 32'(bus.Stall), 32'd1);
      checkOutput($sformatf("timeout.wait%0d.BusError", c), 32'(bus.BusError), 32'd0);
      stepCycle();
    end
    checkAll("timeout.done", 0, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
    driveInputs(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    stepCycle();
    checkAll("timeout.idle", 0, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
`else
    for (int c = 0; c < 20; c++) begin
      checkOutput($sformatf("longwait%0d.Stall", c), 32'(bus.Stall), 32'd1);
      checkOutput($sformatf("longwait%0d.BusError", c), 32'(bus.BusError), 32'd0);
      stepCycle();
    end
    driveInputs(1, 0, 32'h100, 32'h0, 1, 1, 32'h0BAD_F00D);
    stepCycle();
    driveInputs(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    #1;
    checkAll("longwait.done", 0, 0, 0, 32'h100, 32'h0, 32'h0BAD_F00D, 0);
    stepCycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
